// File: rtl/lvds_clk_div_bank_if.sv
// Configuration and output bundle of the LVDS divided-clock bank.
// The master drives the per-channel ratio/phase configuration; the slave
// (the divider bank) returns the divided clocks, strobes and qualified lock.
interface lvds_clk_div_bank_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8
);
    logic [NUM_CH*CNT_W-1:0] cfg_div;
    logic [NUM_CH*CNT_W-1:0] cfg_phase;
    logic                    cfg_load;
    logic [NUM_CH-1:0]       outclk;
    logic [NUM_CH-1:0]       outce;
    logic                    locked;

    modport master (
        output cfg_div, cfg_phase, cfg_load,
        input  outclk, outce, locked
    );

    modport slave (
        input  cfg_div, cfg_phase, cfg_load,
        output outclk, outce, locked
    );
endinterface

// File: rtl/lvds_clk_div_bank.sv
// Clock-enable / divided-clock generator following the LVDS PLL output.
// Qualifies the PLL lock, then runs NUM_CH phase-aligned counters whose
// period and phase come from shadow registers loaded by cfg_load.
module lvds_clk_div_bank #(
    parameter int NUM_CH      = 3,
    parameter int CNT_W       = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    lvds_clk_div_bank_if.slave  bus
);
    localparam int QW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, QUALIFY, RUN} state_t;

    state_t            state_q;
    logic [QW-1:0]     qcnt_q;
    logic              locked_q;
    logic              sync1_q;
    logic              lk_s;
    logic              realign_q;
    logic              go_run;

    logic [CNT_W-1:0]  div_q   [NUM_CH];
    logic [CNT_W-1:0]  ph_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  div_c   [NUM_CH];
    logic [CNT_W-1:0]  ph_c    [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] outclk_q;
    logic [NUM_CH-1:0] outce_q;

    // Two-flop synchroniser for the asynchronous PLL lock.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real hardware does.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            lk_s    <= sync1_q;
        end
    end

    // Clamp period and saturate phase on the way into the shadow registers,
    // so the counters never need a modulo operation.
    // NOTE: every always_comb output is given a value on every path; a
    // missed assignment would infer a latch.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_c[i] = bus.cfg_div[i*CNT_W +: CNT_W];
            ph_c[i]  = bus.cfg_phase[i*CNT_W +: CNT_W];
            if (div_c[i] < CNT_W'(2))
                div_c[i] = CNT_W'(2);
            if (ph_c[i] >= div_c[i])
                ph_c[i] = div_c[i] - CNT_W'(1);
        end
    end

    // Shadow registers and the one-cycle-delayed realignment request.
    // NOTE: the shadow array is reset because an unconfigured bank must
    // still divide by 2 with zero phase after reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            realign_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= CNT_W'(2);
                ph_q[i]  <= '0;
            end
        end else begin
            realign_q <= bus.cfg_load;
            if (bus.cfg_load) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    div_q[i] <= div_c[i];
                    ph_q[i]  <= ph_c[i];
                end
            end
        end
    end

    // Lock qualification FSM with registered locked output.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= IDLE;
            qcnt_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    qcnt_q   <= '0;
                    locked_q <= 1'b0;
                    if (lk_s)
                        state_q <= QUALIFY;
                end
                QUALIFY: begin
                    if (!lk_s) begin
                        state_q <= IDLE;
                        qcnt_q  <= '0;
                    end else if (qcnt_q == QW'(LOCK_CYCLES - 1)) begin
                        state_q  <= RUN;
                        qcnt_q   <= '0;
                        locked_q <= 1'b1;
                    end else begin
                        qcnt_q <= qcnt_q + QW'(1);
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    qcnt_q   <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Next channel counts: aligned reload on RUN entry or realignment,
    // otherwise increment with wrap at P-1.
    always_comb begin
        go_run = lk_s && ((state_q == RUN) ||
                 (state_q == QUALIFY && qcnt_q == QW'(LOCK_CYCLES - 1)));
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_q == QUALIFY || realign_q)
                cnt_nxt[i] = (ph_q[i] == '0) ? '0 : div_q[i] - ph_q[i];
            else if (cnt_q[i] == div_q[i] - CNT_W'(1))
                cnt_nxt[i] = '0;
            else
                cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        end
    end

    // Channel counters with registered clock and strobe outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            outclk_q <= '0;
            outce_q  <= '0;
            for (int i = 0; i < NUM_CH; i++)
                cnt_q[i] <= '0;
        end else if (go_run) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= cnt_nxt[i];
                outce_q[i]  <= (cnt_nxt[i] == '0);
                outclk_q[i] <= (cnt_nxt[i] < (div_q[i] >> 1));
            end
        end else begin
            outclk_q <= '0;
            outce_q  <= '0;
        end
    end

    assign bus.outclk = outclk_q;
    assign bus.outce  = outce_q;
    assign bus.locked = locked_q;
endmodule
